// File: rtl/cnn_ctrl_pkg.sv
// Shared constants and state encoding for the CNN load/run sequencer.
package cnn_ctrl_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int KERNEL_SIZE  = 4;
  localparam int CHUNK_LEN    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NUM_FEATURES = 3;
  localparam int BIAS_LEN     = NUM_FEATURES + 1;
  localparam int FC_CHUNKS    = 27;
  localparam int RUN_CYCLES   = 631;

  typedef enum logic [3:0] {
    IDLE,
    LD_FEAT,
    WR_FEAT,
    LD_BIAS,
    WR_BIAS,
    LD_FC,
    WR_FC,
    FIRE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/chunk_packer.sv
// Packs an incoming byte stream into a lane register; lane index advances per accepted byte.
module chunk_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  localparam int LANE_W    = $clog2(LANES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              en,
  input  logic [LANE_W-1:0]                 last_lane,
  input  logic [DATA_WIDTH-1:0]             data,
  output logic [LANES-1:0][DATA_WIDTH-1:0]  chunk_next,
  output logic                              last
);

  logic [LANES-1:0][DATA_WIDTH-1:0] chunk_q;
  logic [LANE_W-1:0]                byte_cnt;

  // chunk_next already includes this cycle's byte so the caller can latch a complete chunk
  always_comb begin
    // NOTE: default first so every path assigns chunk_next and no latch is inferred
    chunk_next = chunk_q;
    if (clear) begin
      chunk_next = '0;
    end else if (en) begin
      chunk_next[byte_cnt] = data;
    end
  end

  assign last = en && (byte_cnt == last_lane);

  // NOTE: the lane register is small enough to reset, which keeps outputs deterministic after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_q  <= '0;
      byte_cnt <= '0;
    end else begin
      chunk_q <= chunk_next;
      if (clear || last) begin
        byte_cnt <= '0;
      end else if (en) begin
        byte_cnt <= byte_cnt + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_load_sequencer.sv
// Loads feature, bias and FC weights from a byte stream into the CNN core, then runs one inference.
module cnn_load_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = cnn_ctrl_pkg::DATA_WIDTH,
  parameter int KERNEL_SIZE  = cnn_ctrl_pkg::KERNEL_SIZE,
  parameter int NUM_FEATURES = cnn_ctrl_pkg::NUM_FEATURES,
  parameter int FC_CHUNKS    = cnn_ctrl_pkg::FC_CHUNKS,
  parameter int RUN_CYCLES   = cnn_ctrl_pkg::RUN_CYCLES
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                cfg_start,
  input  logic                                                run_start,
  input  logic                                                s_valid,
  input  logic [DATA_WIDTH-1:0]                               s_data,
  output logic                                                s_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  feature_weights_input,
  output logic [1:0]                                          feature_writeAddr,
  output logic                                                feature_WrEn,
  output logic [NUM_FEATURES:0][DATA_WIDTH-1:0]               bias_weights_input,
  output logic                                                bias_WrEn,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  fullyconnected_weights_input,
  output logic [4:0]                                          fullyconnected_writeAddr,
  output logic                                                fullyconnected_WrEn,
  output logic                                                convolution_enable,
  input  logic [DATA_WIDTH-1:0]                               cnn_output,
  output logic [DATA_WIDTH-1:0]                               result,
  output logic                                                result_valid,
  output logic                                                busy,
  output logic                                                weights_loaded,
  output logic                                                err
);

  localparam int LANES  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BLEN   = NUM_FEATURES + 1;
  localparam int LANE_W = $clog2(LANES);
  localparam int RUN_W  = $clog2(RUN_CYCLES);

  localparam logic [LANE_W-1:0] CHUNK_LAST = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0] BIAS_LAST  = LANE_W'(BLEN - 1);
  localparam logic [1:0]        FEAT_LAST  = 2'(NUM_FEATURES - 1);
  localparam logic [4:0]        FC_LAST    = 5'(FC_CHUNKS - 1);

  state_t                           state, state_next;
  logic                             accept;
  logic                             last;
  logic                             packer_clear;
  logic [LANE_W-1:0]                last_lane;
  logic [LANES-1:0][DATA_WIDTH-1:0] chunk_next;
  logic [RUN_W-1:0]                 run_cnt;

  assign accept = s_valid && s_ready;

  chunk_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .en         (accept),
    .last_lane  (last_lane),
    .data       (s_data),
    .chunk_next (chunk_next),
    .last       (last)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next = LD_FEAT;
        end else if (run_start && weights_loaded) begin
          state_next = FIRE;
        end
      end
      LD_FEAT: if (last) state_next = WR_FEAT;
      WR_FEAT: state_next = (feature_writeAddr == FEAT_LAST) ? LD_BIAS : LD_FEAT;
      LD_BIAS: if (last) state_next = WR_BIAS;
      WR_BIAS: state_next = LD_FC;
      LD_FC:   if (last) state_next = WR_FC;
      WR_FC:   state_next = (fullyconnected_writeAddr == FC_LAST) ? FIRE : LD_FC;
      FIRE:    state_next = RUN;
      RUN:     if (run_cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are pure state decodes; the lane register is cleared whenever no load is in progress
  always_comb begin
    s_ready             = 1'b0;
    busy                = 1'b1;
    feature_WrEn        = 1'b1;
    bias_WrEn           = 1'b1;
    fullyconnected_WrEn = 1'b1;
    convolution_enable  = 1'b1;
    result_valid        = 1'b0;
    case (state)
      IDLE:                 busy                = 1'b0;
      LD_FEAT, LD_BIAS,
      LD_FC:                s_ready             = 1'b1;
      WR_FEAT:              feature_WrEn        = 1'b0;
      WR_BIAS:              bias_WrEn           = 1'b0;
      WR_FC:                fullyconnected_WrEn = 1'b0;
      FIRE:                 convolution_enable  = 1'b0;
      DONE:                 result_valid        = 1'b1;
      default: ;
    endcase
    packer_clear = !s_ready;
    last_lane    = (state == LD_BIAS) ? BIAS_LAST : CHUNK_LAST;
  end

  // Chunk outputs latch on the last byte, so data is settled before and after the write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feature_weights_input        <= '0;
      feature_writeAddr            <= '0;
      bias_weights_input           <= '0;
      fullyconnected_weights_input <= '0;
      fullyconnected_writeAddr     <= '0;
      run_cnt                      <= '0;
      result                       <= '0;
      weights_loaded               <= 1'b0;
      err                          <= 1'b0;
    end else begin
      err <= (state == IDLE) && run_start && !cfg_start && !weights_loaded;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            feature_writeAddr        <= '0;
            fullyconnected_writeAddr <= '0;
            weights_loaded           <= 1'b0;
          end
        end
        LD_FEAT: if (last) feature_weights_input <= chunk_next;
        WR_FEAT: feature_writeAddr <= feature_writeAddr + 2'd1;
        LD_BIAS: if (last) bias_weights_input <= chunk_next[BLEN-1:0];
        LD_FC:   if (last) fullyconnected_weights_input <= chunk_next;
        WR_FC: begin
          fullyconnected_writeAddr <= fullyconnected_writeAddr + 5'd1;
          if (fullyconnected_writeAddr == FC_LAST) begin
            weights_loaded <= 1'b1;
          end
        end
        FIRE: run_cnt <= RUN_W'(RUN_CYCLES - 1);
        RUN: begin
          if (run_cnt == '0) begin
            result <= cnn_output;
          end else begin
            run_cnt <= run_cnt - RUN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
